// File: rtl/icache_direct_pkg.sv
// ---------------------------------------------------------------------------
// icache_direct_pkg
//   Shared widths and FSM state encoding for the direct-mapped instruction
//   cache (icache_direct) and its storage sub-module (icache_array).
// ---------------------------------------------------------------------------
package icache_direct_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 32;

    typedef enum logic [1:0] {
        ICACHE_IDLE = 2'd0,
        ICACHE_FILL = 2'd1,
        ICACHE_RESP = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// ---------------------------------------------------------------------------
// icache_array
//   Valid / tag / data storage for the direct-mapped instruction cache.
//   Ports:
//     clk_i, rst_ni      clock, async active-low reset (clears valid bits only)
//     en_i               global enable; 0 blocks every write
//     rd_idx_i/rd_word_i combinational lookup address
//     rd_valid_o/rd_tag_o/rd_data_o  lookup result
//     wr_en_i            write one data word at wr_idx_i/wr_word_i
//     line_done_i        set valid and write line_tag_i for wr_idx_i
// ---------------------------------------------------------------------------
module icache_array
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_BITS    = 22
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic [INDEX_BITS-1:0]  rd_idx_i,
    input  logic [OFFSET_BITS-1:0] rd_word_i,
    output logic                   rd_valid_o,
    output logic [TAG_BITS-1:0]    rd_tag_o,
    output logic [INSTR_WIDTH-1:0] rd_data_o,
    input  logic                   wr_en_i,
    input  logic [INDEX_BITS-1:0]  wr_idx_i,
    input  logic [OFFSET_BITS-1:0] wr_word_i,
    input  logic [INSTR_WIDTH-1:0] wr_data_i,
    input  logic                   line_done_i,
    input  logic [TAG_BITS-1:0]    line_tag_i
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    logic [LINES-1:0]       valid_q;
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [INSTR_WIDTH-1:0] data_q [LINES*WORDS];

    // Only valid bits need reset; tag/data are don't-care while invalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (en_i && line_done_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i && wr_en_i) begin
            data_q[{wr_idx_i, wr_word_i}] <= wr_data_i;
        end
        if (en_i && line_done_i) begin
            tag_q[wr_idx_i] <= line_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[{rd_idx_i, rd_word_i}];

endmodule

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, read-only instruction cache. 1-cycle hit; on a miss the
//   whole line is filled word 0..N-1 from memory, then the requested word is
//   returned. A fetcher flush drops any undelivered response.
//   Ports:
//     clk_in, rst_n_in      clock, async active-low reset
//     rdy_in                0 freezes all state and outputs
//     fetch_req_in/pc_in    fetch request (pc bits [1:0] ignored)
//     fetch_ready_out       request accepted this cycle (IDLE)
//     fetch_valid_out/instr_out  1-cycle response pulse + word
//     flush_in              redirect: drop undelivered response
//     mem_req_out/addr_out  word read request to memory
//     mem_valid_in/data_in  memory response pulse + word
//   Optional build macro ICACHE_STAT_EN adds hit_cnt_out / miss_cnt_out.
// ---------------------------------------------------------------------------
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   fetch_req_in,
    input  logic [ADDR_WIDTH-1:0]  fetch_pc_in,
    output logic                   fetch_ready_out,
    output logic                   fetch_valid_out,
    output logic [INSTR_WIDTH-1:0] fetch_instr_out,
    input  logic                   flush_in,
    output logic                   mem_req_out,
    output logic [ADDR_WIDTH-1:0]  mem_addr_out,
    input  logic                   mem_valid_in,
    input  logic [INSTR_WIDTH-1:0] mem_data_in
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]            hit_cnt_out,
    output logic [31:0]            miss_cnt_out
`endif
);

    localparam int TAG_BITS = ADDR_WIDTH - 2 - OFFSET_BITS - INDEX_BITS;
    localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

    // Request address split
    logic [TAG_BITS-1:0]    req_tag;
    logic [INDEX_BITS-1:0]  req_idx;
    logic [OFFSET_BITS-1:0] req_word;
    logic [1:0]             unused_pc_lsb;

    assign req_tag       = fetch_pc_in[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_idx       = fetch_pc_in[2+OFFSET_BITS +: INDEX_BITS];
    assign req_word      = fetch_pc_in[2 +: OFFSET_BITS];
    assign unused_pc_lsb = fetch_pc_in[1:0];

    icache_state_e          state_q, state_d;
    logic [TAG_BITS-1:0]    tag_q, tag_d;
    logic [INDEX_BITS-1:0]  idx_q, idx_d;
    logic [OFFSET_BITS-1:0] word_q, word_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic                   drop_q, drop_d;
    logic                   fvalid_q, fvalid_d;
    logic [INSTR_WIDTH-1:0] finstr_q, finstr_d;
    logic                   mreq_q, mreq_d;
    logic [ADDR_WIDTH-1:0]  maddr_q, maddr_d;

    // Array interface
    logic [INDEX_BITS-1:0]  rd_idx;
    logic [OFFSET_BITS-1:0] rd_word;
    logic                   rd_valid;
    logic [TAG_BITS-1:0]    rd_tag;
    logic [INSTR_WIDTH-1:0] rd_data;
    logic                   wr_en, line_done;

    logic accept, hit;

    // IDLE looks up the incoming PC; otherwise the latched request (used to
    // pick up an earlier-filled word when the line completes).
    assign rd_idx  = (state_q == ICACHE_IDLE) ? req_idx  : idx_q;
    assign rd_word = (state_q == ICACHE_IDLE) ? req_word : word_q;
    assign hit     = rd_valid && (rd_tag == req_tag);
    // Flush in the same cycle wins over a new request.
    assign accept  = (state_q == ICACHE_IDLE) && fetch_req_in && !flush_in;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk_i      (clk_in),
        .rst_ni     (rst_n_in),
        .en_i       (rdy_in),
        .rd_idx_i   (rd_idx),
        .rd_word_i  (rd_word),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (idx_q),
        .wr_word_i  (cnt_q),
        .wr_data_i  (mem_data_in),
        .line_done_i(line_done),
        .line_tag_i (tag_q)
    );

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        idx_d     = idx_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        fvalid_d  = 1'b0;
        finstr_d  = finstr_q;
        mreq_d    = mreq_q;
        maddr_d   = maddr_q;
        wr_en     = 1'b0;
        line_done = 1'b0;

        unique case (state_q)
            ICACHE_IDLE: begin
                drop_d = 1'b0;
                if (accept) begin
                    tag_d  = req_tag;
                    idx_d  = req_idx;
                    word_d = req_word;
                    if (hit) begin
                        fvalid_d = 1'b1;
                        finstr_d = rd_data;
                    end else begin
                        state_d = ICACHE_FILL;
                        cnt_d   = '0;
                        mreq_d  = 1'b1;
                        maddr_d = {req_tag, req_idx, {OFFSET_BITS{1'b0}}, 2'b00};
                    end
                end
            end
            ICACHE_FILL: begin
                // Memory cannot abort, so a flush only marks the response dead.
                drop_d = drop_q | flush_in;
                if (mreq_q) begin
                    if (mem_valid_in) begin
                        wr_en  = 1'b1;
                        mreq_d = 1'b0;
                        if (cnt_q == LAST_WORD) begin
                            line_done = 1'b1;
                            state_d   = ICACHE_RESP;
                            fvalid_d  = !(drop_q || flush_in);
                            // The last word is still in flight to the array.
                            finstr_d  = (word_q == LAST_WORD) ? mem_data_in : rd_data;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    // One idle cycle after each beat, then request the next word.
                    mreq_d  = 1'b1;
                    maddr_d = {tag_q, idx_q, cnt_q, 2'b00};
                end
            end
            ICACHE_RESP: begin
                state_d = ICACHE_IDLE;
                drop_d  = 1'b0;
            end
            default: state_d = ICACHE_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ICACHE_IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            fvalid_q <= 1'b0;
            finstr_q <= '0;
            mreq_q   <= 1'b0;
            maddr_q  <= '0;
        end else if (rdy_in) begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            fvalid_q <= fvalid_d;
            finstr_q <= finstr_d;
            mreq_q   <= mreq_d;
            maddr_q  <= maddr_d;
        end
    end

    assign fetch_ready_out = (state_q == ICACHE_IDLE);
    assign fetch_valid_out = fvalid_q;
    assign fetch_instr_out = finstr_q;
    assign mem_req_out     = mreq_q;
    assign mem_addr_out    = maddr_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (rdy_in && accept) begin
            if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_out  = hit_cnt_q;
    assign miss_cnt_out = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic        mvalid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] mdata = '0;
    logic        fready, fvalid, mreq;
    logic [31:0] finstr, maddr;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    icache_direct #(.INDEX_BITS(6), .OFFSET_BITS(2)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .rdy_in         (rdy),
        .fetch_req_in   (req),
        .fetch_pc_in    (pc),
        .fetch_ready_out(fready),
        .fetch_valid_out(fvalid),
        .fetch_instr_out(finstr),
        .flush_in       (flush),
        .mem_req_out    (mreq),
        .mem_addr_out   (maddr),
        .mem_valid_in   (mvalid),
        .mem_data_in    (mdata)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt_out    (hit_cnt),
        .miss_cnt_out   (miss_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: which line holds which tag, plus expected stats.
    bit          ref_valid [64];
    logic [21:0] ref_tag   [64];
    int          exp_hit = 0;
    int          exp_miss = 0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    task automatic chk_stats();
`ifdef ICACHE_STAT_EN
        chk("hit_cnt", hit_cnt, exp_hit);
        chk("miss_cnt", miss_cnt, exp_miss);
`endif
    endtask

    // Acts as the memory controller for one line fill. Entered at a negedge
    // right after the miss was accepted; returns at a negedge with the cache
    // back in IDLE. *_at selects the beat at which to flush/stall/reset.
    task automatic serve_miss(input logic [31:0] pa, input int flush_at,
                              input int stall_at, input int rst_at);
        logic [31:0] base;
        bit          dropped;
        int          t;
        base    = {pa[31:4], 4'h0};
        dropped = 1'b0;
        for (int w = 0; w < WORDS; w++) begin
            t = 0;
            while (!mreq && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!mreq) begin
                chk("mreq_timeout", 32'(mreq), 32'd1);
                return;
            end
            chk("fill_addr", maddr, base + 32'(4 * w));
            chk("fill_not_ready", 32'(fready), 32'd0);
            if (w == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mreq", 32'(mreq), 32'd0);
                chk("rst_ready", 32'(fready), 32'd1);
                ref_reset();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("mreq_hold", 32'(mreq), 32'd1);
                chk("maddr_hold", maddr, base + 32'(4 * w));
            end
            mvalid = 1'b1;
            mdata  = memval(base + 32'(4 * w));
            if (w == flush_at) begin
                flush   = 1'b1;
                dropped = 1'b1;
            end
            if (w == stall_at) begin
                rdy = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_mreq", 32'(mreq), 32'd1);
                    chk("stall_maddr", maddr, base + 32'(4 * w));
                    chk("stall_fvalid", 32'(fvalid), 32'd0);
                end
                rdy = 1'b1;
            end
            @(negedge clk);
            mvalid = 1'b0;
            flush  = 1'b0;
            chk("mreq_gap", 32'(mreq), 32'd0);
        end
        chk("resp_valid", 32'(fvalid), 32'(!dropped));
        if (!dropped) chk("resp_data", finstr, memval({pa[31:2], 2'b00}));
        ref_valid[pa[9:4]] = 1'b1;
        ref_tag[pa[9:4]]   = pa[31:10];
        @(negedge clk);
        chk("resp_done_ready", 32'(fready), 32'd1);
        chk("resp_pulse", 32'(fvalid), 32'd0);
    endtask

    // Presents one fetch at the current negedge and checks the outcome.
    task automatic do_fetch(input logic [31:0] pa, input bit fl,
                            input int flush_at, input int stall_at, input int rst_at);
        bit hit;
        chk("idle_ready", 32'(fready), 32'd1);
        hit   = ref_valid[pa[9:4]] && (ref_tag[pa[9:4]] == pa[31:10]);
        req   = 1'b1;
        pc    = pa;
        flush = fl;
        @(negedge clk);
        req   = 1'b0;
        flush = 1'b0;
        if (fl) begin
            chk("flush_no_valid", 32'(fvalid), 32'd0);
            chk("flush_no_mreq", 32'(mreq), 32'd0);
        end else if (hit) begin
            exp_hit++;
            chk("hit_valid", 32'(fvalid), 32'd1);
            chk("hit_data", finstr, memval({pa[31:2], 2'b00}));
            chk("hit_no_mreq", 32'(mreq), 32'd0);
        end else begin
            exp_miss++;
            chk("miss_no_valid", 32'(fvalid), 32'd0);
            serve_miss(pa, flush_at, stall_at, rst_at);
        end
        chk_stats();
    endtask

    initial begin
        logic [31:0] rpc;
        ref_reset();
        #1;
        chk("rst_fvalid", 32'(fvalid), 32'd0);
        chk("rst_mreq0", 32'(mreq), 32'd0);
        chk("rst_finstr", finstr, 32'd0);
        chk("rst_maddr", maddr, 32'd0);
        chk("rst_fready", 32'(fready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, then back-to-back hits
        do_fetch(32'h100, 0, -1, -1, -1);
        do_fetch(32'h108, 0, -1, -1, -1);
        do_fetch(32'h10C, 0, -1, -1, -1);
        // Conflict on the same index
        do_fetch(32'h500, 0, -1, -1, -1);
        do_fetch(32'h100, 0, -1, -1, -1);
        // Flush during fill, line still installed
        do_fetch(32'h200, 0, 1, -1, -1);
        do_fetch(32'h204, 0, -1, -1, -1);
        // Flush together with a request in IDLE
        do_fetch(32'h208, 1, -1, -1, -1);
        // Stall with mem_valid held
        do_fetch(32'h30C, 0, -1, 1, -1);
        do_fetch(32'h300, 0, -1, -1, -1);
        // Reset mid-fill, then the same line misses
        do_fetch(32'h400, 0, -1, -1, 3);
        do_fetch(32'h400, 0, -1, -1, -1);
        do_fetch(32'h100, 0, -1, -1, -1);

        // Random mix over a small address pool to force hits and conflicts
        for (int i = 0; i < 60; i++) begin
            rpc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            do_fetch(rpc, ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                     -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
